cache_miss_alloc: RTL and testbench

- Write/miss-side companion to the read-hit tag compare in the 8-way set-associative cache.
- Accepts one access per transaction and consumes the hit/way result from the compare stage.
- On a hit, it updates tree pseudo-LRU state and marks the line dirty on writes.
- On a miss, it picks a victim way, writes back a dirty victim, requests a line fill, then installs the new tag.

---
 rtl/cache_miss_alloc.sv | 271 +++++++++++++++++++++++++++
 tb/tb_cache_miss_alloc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_alloc.sv
// Miss/allocate controller for the 8-way set-associative cache: tree PLRU, victim select, writeback, fill, install.
// Optional macro CACHE_STATS_EN adds saturating hit/miss/writeback counters on the stat_* ports.
//
// state     | meaning
// S_IDLE    | waiting for a request, req_ready=1
// S_LOOKUP  | compare-stage result valid; resolve hit or choose victim
// S_EVICT   | writeback of dirty victim outstanding
// S_FILL    | line fill outstanding
// S_INSTALL | write new tag, update PLRU, signal completion
module cache_miss_alloc #(
    parameter int WAYS     = 8,
    parameter int WAYS_REP = 3,
    parameter int INDEX    = 3,
    parameter int TAG_W    = 12
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [INDEX-1:0]      req_index,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic                  hit,
    input  logic [WAYS_REP-1:0]   hit_way,
    input  logic [WAYS-1:0]       set_valid,
    input  logic [WAYS-1:0]       set_dirty,
    input  logic [WAYS*TAG_W-1:0] set_tags,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [INDEX-1:0]      wb_index,
    output logic [TAG_W-1:0]      wb_tag,
    output logic [WAYS_REP-1:0]   wb_way,
    output logic                  fill_valid,
    input  logic                  fill_ready,
    output logic [WAYS_REP-1:0]   fill_way,
    output logic                  tag_we,
    output logic [WAYS_REP-1:0]   tag_we_way,
    output logic [TAG_W-1:0]      tag_we_tag,
    output logic                  tag_we_dirty,
    output logic                  done,
    output logic [WAYS_REP-1:0]   done_way,
    output logic                  done_miss,
    output logic [15:0]           stat_hits,
    output logic [15:0]           stat_misses,
    output logic [15:0]           stat_wbs
);

    localparam int SETS = 2**INDEX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_INSTALL
    } state_t;

    state_t                r_state;
    logic                  r_write;
    logic [INDEX-1:0]      r_index;
    logic [TAG_W-1:0]      r_tag;
    logic [WAYS_REP-1:0]   r_victim;
    logic [TAG_W-1:0]      r_wb_tag;
    logic [6:0]            r_plru [SETS];

    logic                  r_req_ready;
    logic                  r_wb_valid;
    logic                  r_fill_valid;
    logic                  r_tag_we;
    logic [WAYS_REP-1:0]   r_tag_we_way;
    logic [TAG_W-1:0]      r_tag_we_tag;
    logic                  r_tag_we_dirty;
    logic                  r_done;
    logic [WAYS_REP-1:0]   r_done_way;
    logic                  r_done_miss;

    logic [6:0]            w_plru_cur;
    logic [WAYS_REP-1:0]   w_plru_vic;
    logic                  w_inv_found;
    logic [WAYS_REP-1:0]   w_inv_way;
    logic [WAYS_REP-1:0]   w_victim;
    logic [TAG_W-1:0]      w_victim_tag;
    logic                  w_victim_dirty;

    // Point every node on way w's path away from w; other nodes keep their value.
    function automatic logic [6:0] plru_touch(input logic [6:0] p, input logic [2:0] w);
        logic [6:0] n;
        n    = p;
        n[0] = ~w[2];
        if (!w[2]) begin
            n[1] = ~w[1];
            if (!w[1]) n[3] = ~w[0];
            else       n[4] = ~w[0];
        end else begin
            n[2] = ~w[1];
            if (!w[1]) n[5] = ~w[0];
            else       n[6] = ~w[0];
        end
        return n;
    endfunction

    function automatic logic [2:0] plru_victim(input logic [6:0] p);
        logic [2:0] v;
        v[2] = p[0];
        if (!p[0]) begin
            v[1] = p[1];
            v[0] = p[1] ? p[4] : p[3];
        end else begin
            v[1] = p[2];
            v[0] = p[2] ? p[6] : p[5];
        end
        return v;
    endfunction

    assign w_plru_cur = r_plru[r_index];
    assign w_plru_vic = plru_victim(w_plru_cur);

    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAYS_REP'(w);
            end
        end
    end

    // An empty way always wins over the PLRU choice.
    assign w_victim       = w_inv_found ? w_inv_way : w_plru_vic;
    assign w_victim_tag   = set_tags[int'(w_victim)*TAG_W +: TAG_W];
    assign w_victim_dirty = set_valid[w_victim] && set_dirty[w_victim];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state        <= S_IDLE;
            r_write        <= 1'b0;
            r_index        <= '0;
            r_tag          <= '0;
            r_victim       <= '0;
            r_wb_tag       <= '0;
            for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
            r_req_ready    <= 1'b1;
            r_wb_valid     <= 1'b0;
            r_fill_valid   <= 1'b0;
            r_tag_we       <= 1'b0;
            r_tag_we_way   <= '0;
            r_tag_we_tag   <= '0;
            r_tag_we_dirty <= 1'b0;
            r_done         <= 1'b0;
            r_done_way     <= '0;
            r_done_miss    <= 1'b0;
        end else begin
            r_tag_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_index     <= req_index;
                        r_tag       <= req_tag;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        r_plru[r_index] <= plru_touch(w_plru_cur, hit_way);
                        if (r_write) begin
                            r_tag_we       <= 1'b1;
                            r_tag_we_way   <= hit_way;
                            r_tag_we_tag   <= r_tag;
                            r_tag_we_dirty <= 1'b1;
                        end
                        r_done      <= 1'b1;
                        r_done_way  <= hit_way;
                        r_done_miss <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_victim <= w_victim;
                        r_wb_tag <= w_victim_tag;
                        if (w_victim_dirty) begin
                            r_wb_valid <= 1'b1;
                            r_state    <= S_EVICT;
                        end else begin
                            r_fill_valid <= 1'b1;
                            r_state      <= S_FILL;
                        end
                    end
                end
                S_EVICT: begin
                    if (wb_ready) begin
                        r_wb_valid   <= 1'b0;
                        r_fill_valid <= 1'b1;
                        r_state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (fill_ready) begin
                        r_fill_valid <= 1'b0;
                        r_state      <= S_INSTALL;
                    end
                end
                S_INSTALL: begin
                    r_plru[r_index] <= plru_touch(w_plru_cur, r_victim);
                    r_tag_we       <= 1'b1;
                    r_tag_we_way   <= r_victim;
                    r_tag_we_tag   <= r_tag;
                    r_tag_we_dirty <= r_write;
                    r_done         <= 1'b1;
                    r_done_way     <= r_victim;
                    r_done_miss    <= 1'b1;
                    r_req_ready    <= 1'b1;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_wb_valid   <= 1'b0;
                    r_fill_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign wb_valid     = r_wb_valid;
    assign wb_index     = r_index;
    assign wb_tag       = r_wb_tag;
    assign wb_way       = r_victim;
    assign fill_valid   = r_fill_valid;
    assign fill_way     = r_victim;
    assign tag_we       = r_tag_we;
    assign tag_we_way   = r_tag_we_way;
    assign tag_we_tag   = r_tag_we_tag;
    assign tag_we_dirty = r_tag_we_dirty;
    assign done         = r_done;
    assign done_way     = r_done_way;
    assign done_miss    = r_done_miss;

`ifdef CACHE_STATS_EN
    logic [15:0] r_stat_hits;
    logic [15:0] r_stat_misses;
    logic [15:0] r_stat_wbs;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
            r_stat_wbs    <= '0;
        end else begin
            if (r_done && !r_done_miss && (r_stat_hits != 16'hFFFF))
                r_stat_hits <= r_stat_hits + 16'd1;
            if (r_done && r_done_miss && (r_stat_misses != 16'hFFFF))
                r_stat_misses <= r_stat_misses + 16'd1;
            if (r_wb_valid && wb_ready && (r_stat_wbs != 16'hFFFF))
                r_stat_wbs <= r_stat_wbs + 16'd1;
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
    assign stat_wbs    = r_stat_wbs;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
    assign stat_wbs    = '0;
`endif

endmodule

// File: tb/tb_cache_miss_alloc.sv
// Directed bench for cache_miss_alloc: scoreboard of expected completions fed by an independent PLRU model.
module tb_cache_miss_alloc;

    logic        clk = 1'b0;
    logic        rstb;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_index;
    logic [11:0] req_tag;
    logic        hit;
    logic [2:0]  hit_way;
    logic [7:0]  set_valid, set_dirty;
    logic [95:0] set_tags;
    logic        wb_valid, wb_ready;
    logic [2:0]  wb_index, wb_way;
    logic [11:0] wb_tag;
    logic        fill_valid, fill_ready;
    logic [2:0]  fill_way;
    logic        tag_we, tag_we_dirty;
    logic [2:0]  tag_we_way;
    logic [11:0] tag_we_tag;
    logic        done, done_miss;
    logic [2:0]  done_way;
    logic [15:0] stat_hits, stat_misses, stat_wbs;

    always #5 clk = ~clk;

    cache_miss_alloc dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_index(req_index), .req_tag(req_tag),
        .hit(hit), .hit_way(hit_way),
        .set_valid(set_valid), .set_dirty(set_dirty), .set_tags(set_tags),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index),
        .wb_tag(wb_tag), .wb_way(wb_way),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_way(fill_way),
        .tag_we(tag_we), .tag_we_way(tag_we_way), .tag_we_tag(tag_we_tag),
        .tag_we_dirty(tag_we_dirty),
        .done(done), .done_way(done_way), .done_miss(done_miss),
        .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
    );

    typedef struct {
        logic [2:0]  way;
        logic        miss;
        logic        we;
        logic [11:0] tag;
        logic        dirty;
        logic        dvic;
        logic [11:0] wbtag;
        logic [2:0]  idx;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] m_plru [8];
    int         total = 0;
    int         bad = 0;
    int         m_hits = 0, m_misses = 0, m_wbs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] m_victim(input logic [6:0] p);
        int         n = 0;
        logic [2:0] w = '0;
        for (int l = 0; l < 3; l++) begin
            w = {w[1:0], p[n]};
            n = 2*n + 1 + int'(p[n]);
        end
        return w;
    endfunction

    function automatic logic [6:0] m_touch(input logic [6:0] p, input logic [2:0] w);
        int         n = 0;
        logic       b;
        logic [6:0] q = p;
        for (int l = 0; l < 3; l++) begin
            b    = w[2-l];
            q[n] = ~b;
            n    = 2*n + 1 + int'(b);
        end
        return q;
    endfunction

    task automatic access(input logic wr, input logic [2:0] idx, input logic [11:0] tg,
                          input logic h, input logic [2:0] hw,
                          input logic [7:0] sv, input logic [7:0] sd,
                          input int wb_dly, input int fill_dly, input logic hold_req);
        exp_t        e;
        exp_t        g;
        logic [6:0]  p;
        logic [95:0] st;
        int          cyc, wbn, fn, exp_lat;
        logic        seen;
        for (int w = 0; w < 8; w++) st[w*12 +: 12] = tg ^ 12'(w*37 + 1);
        p       = m_plru[idx];
        e.idx   = idx;
        e.tag   = tg;
        e.wbtag = '0;
        if (h) begin
            e.way = hw; e.miss = 1'b0; e.we = wr; e.dirty = 1'b1; e.dvic = 1'b0;
            m_plru[idx] = m_touch(p, hw);
            m_hits++;
        end else begin
            e.way = m_victim(p);
            for (int w = 7; w >= 0; w--) if (!sv[w]) e.way = 3'(w);
            e.miss  = 1'b1;
            e.we    = 1'b1;
            e.dirty = wr;
            e.dvic  = sv[e.way] && sd[e.way];
            e.wbtag = st[int'(e.way)*12 +: 12];
            m_plru[idx] = m_touch(p, e.way);
            m_misses++;
            if (e.dvic) m_wbs++;
        end
        sb.push_back(e);
        exp_lat = h ? 2 : 4 + fill_dly + (e.dvic ? wb_dly + 1 : 0);

        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_index = idx; req_tag = tg;
        hit = h; hit_way = hw; set_valid = sv; set_dirty = sd; set_tags = st;
        wb_ready   = (wb_dly == 0);
        fill_ready = (fill_dly == 0);
        chk("req_ready_idle", req_ready, 1);
        @(negedge clk);
        if (!hold_req) req_valid = 1'b0;
        cyc = 1; wbn = 0; fn = 0; seen = 1'b0;
        while (!seen && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (wb_valid) begin
                wbn++;
                chk("wb_way", wb_way, e.way);
                chk("wb_tag", wb_tag, e.wbtag);
                chk("wb_index", wb_index, idx);
                wb_ready = (wb_dly == 0) || (wbn > wb_dly);
            end else if (wb_dly != 0) begin
                wb_ready = 1'b0;
            end
            if (fill_valid) begin
                fn++;
                chk("fill_way", fill_way, e.way);
                fill_ready = (fill_dly == 0) || (fn > fill_dly);
            end else if (fill_dly != 0) begin
                fill_ready = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                if (sb.size() > 0) begin
                    g = sb.pop_front();
                    chk("done_way", done_way, g.way);
                    chk("done_miss", done_miss, g.miss);
                    chk("tag_we", tag_we, g.we);
                    if (g.we) begin
                        chk("tag_we_way", tag_we_way, g.way);
                        chk("tag_we_tag", tag_we_tag, g.tag);
                        chk("tag_we_dirty", tag_we_dirty, g.dirty);
                    end
                end
                chk("latency", cyc, exp_lat);
                chk("wb_cycles", wbn, e.dvic ? wb_dly + 1 : 0);
                chk("fill_cycles", fn, e.miss ? fill_dly + 1 : 0);
            end
        end
        chk("done_seen", seen, 1);
        if (!seen) sb.delete();
        req_valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("tag_we_pulse", tag_we, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    task automatic chk_stats();
`ifdef CACHE_STATS_EN
        chk("stat_hits", stat_hits, 32'(m_hits));
        chk("stat_misses", stat_misses, 32'(m_misses));
        chk("stat_wbs", stat_wbs, 32'(m_wbs));
`else
        chk("stat_hits", stat_hits, 0);
        chk("stat_misses", stat_misses, 0);
        chk("stat_wbs", stat_wbs, 0);
`endif
    endtask

    initial begin
        rstb = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_index = '0; req_tag = '0;
        hit = 1'b0; hit_way = '0; set_valid = '0; set_dirty = '0; set_tags = '0;
        wb_ready = 1'b0; fill_ready = 1'b0;
        for (int s = 0; s < 8; s++) m_plru[s] = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_tag_we", tag_we, 0);
        chk("rst_done", done, 0);
        chk("rst_done_way", done_way, 0);
        chk("rst_done_miss", done_miss, 0);
        chk("rst_wb_way", wb_way, 0);
        chk_stats();
        rstb = 1'b1;

        access(1'b0, 3'd1, 12'h111, 1'b0, 3'd0, 8'hFF, 8'h00, 0, 0, 1'b0);
        access(1'b0, 3'd1, 12'h222, 1'b0, 3'd0, 8'hFF, 8'h00, 0, 0, 1'b0);
        access(1'b1, 3'd3, 12'h333, 1'b1, 3'd5, 8'hFF, 8'h00, 0, 0, 1'b0);
        access(1'b0, 3'd3, 12'h334, 1'b1, 3'd5, 8'hDF, 8'h00, 0, 0, 1'b1);
        access(1'b0, 3'd2, 12'h444, 1'b0, 3'd0, 8'hFB, 8'hFF, 0, 0, 1'b0);
        access(1'b1, 3'd1, 12'h555, 1'b0, 3'd0, 8'hFF, 8'hFF, 3, 2, 1'b0);
        access(1'b0, 3'd3, 12'h666, 1'b0, 3'd0, 8'hFF, 8'h00, 0, 0, 1'b0);
        chk_stats();

        // Abandon a transaction while the writeback is still outstanding.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_index = 3'd4; req_tag = 12'h7A7;
        hit = 1'b0; set_valid = 8'hFF; set_dirty = 8'hFF;
        wb_ready = 1'b0; fill_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("evict_wb_valid", wb_valid, 1);
        @(negedge clk);
        chk("evict_wb_hold", wb_valid, 1);
        rstb = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_fill_valid", fill_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_tag_we", tag_we, 0);
        for (int s = 0; s < 8; s++) m_plru[s] = '0;
        sb.delete();
        m_hits = 0; m_misses = 0; m_wbs = 0;
        chk_stats();
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_tag_we", tag_we, 0);
        end

        access(1'b0, 3'd1, 12'h777, 1'b0, 3'd0, 8'hFF, 8'h00, 0, 0, 1'b0);
        chk_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
